reg_file: RTL



---
 rtl/reg_file.sv | 65 ++++++
 1 files changed

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one clocked write port.
// x0 has no storage and always reads zero; optional same-cycle write bypass.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] mem_d [1:DEPTH-1];
  logic                  wr_en;
  logic                  byp1;
  logic                  byp2;

  assign wr_en = we && (rd_addr != '0);

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (rd_addr == ADDR_WIDTH'(i))) begin
        mem_d[i] = rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Bypass is gated by rst_n so a held reset forces every read to zero.
  assign byp1 = BYPASS && rst_n && wr_en && (rd_addr == rs1_addr);
  assign byp2 = BYPASS && rst_n && wr_en && (rd_addr == rs2_addr);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rs1_addr == ADDR_WIDTH'(i)) rs1_data = mem_q[i];
      if (rs2_addr == ADDR_WIDTH'(i)) rs2_data = mem_q[i];
    end
    if (byp1) rs1_data = rd_data;
    if (byp2) rs2_data = rd_data;
  end

endmodule
